// File: rtl/if_id_buffer.sv
// Purpose : instruction buffer / pipeline register between IF and ID; circular FIFO of {instr, pc}.
// Latency : an entry pushed in cycle N is visible on out_* in cycle N+1 (no same-cycle bypass).
// Backpr. : in_ready drops when FULL (independent of out_ready); IF holds instr/pc until accepted.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous discard of all entries (taken branch / jump)
//   in_valid/in_ready   IF handshake carrying in_instr / in_pc
//   out_valid/out_ready ID handshake; out_instr = NOP_INST and out_pc = 0 when empty
//   bubble_cnt          saturating count of cycles where ID is ready but the buffer is empty;
//                       present only when the IFID_PERF_EN macro is defined
module if_id_buffer #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
`ifdef IFID_PERF_EN
    ,
    output logic [31:0] bubble_cnt
`endif
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    // Storage array; data is never reset, only the pointers and count are.
    logic [31:0] r_instr_mem [DEPTH];
    logic [31:0] r_pc_mem    [DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);

    // A flush discards whatever IF presents in the same cycle, so the fetch is
    // reported as taken (in_ready high) even if the buffer is currently full;
    // otherwise IF would stall and re-present a wrong-path instruction.
    assign in_ready  = ~w_full | flush;
    assign out_valid = ~w_empty;
    assign out_instr = w_empty ? NOP_INST : r_instr_mem[r_rd_ptr];
    assign out_pc    = w_empty ? 32'h0    : r_pc_mem[r_rd_ptr];

    // Flush overrides any push or pop in the same cycle.
    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = out_valid & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= in_instr;
            r_pc_mem[r_wr_ptr]    <= in_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef IFID_PERF_EN
    // ID idle waiting on fetch; survives flush, saturates instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (out_ready && !out_valid && (bubble_cnt != 32'hFFFF_FFFF)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Purpose : directed self-checking bench for if_id_buffer (DEPTH = 2).
// Latency : inputs driven and outputs sampled at the falling edge; state moves at the rising edge.
// Backpr. : exercises full-buffer stall, empty-pop, flush while full, pointer wrap and reset.
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
`ifdef IFID_PERF_EN
    logic [31:0] bubble_cnt;
`endif

    localparam logic [31:0] NOP = 32'h00000013;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_id_buffer #(.DEPTH(2), .NOP_INST(NOP)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_ready (out_ready)
`ifdef IFID_PERF_EN
        ,
        .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock: rising edge, then back to the falling edge for drive/sample.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Instruction word tagged with its pc so order errors show in both fields.
    function automatic logic [31:0] ins(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic r);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins(pc);
        out_ready = r;
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_pc"}, out_pc, pc);
        chk({tag, "_ins"}, out_instr, ins(pc));
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_ins"}, out_instr, NOP);
        chk({tag, "_pc"}, out_pc, 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        @(negedge clk); #1;

        // Reset state.
        chk_empty("rst");
        chk("rst_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Single push, no bypass, visible next cycle.
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h0; out_ready = 1'b0;
        #1;
        chk("nobypass_vld", {31'd0, out_valid}, 32'd0);
        step();
        in_valid = 1'b0;
        chk("single_vld", {31'd0, out_valid}, 32'd1);
        chk("single_ins", out_instr, 32'h00500093);
        chk("single_pc", out_pc, 32'h0);
        drive(1'b0, 32'h0, 1'b1);
        step();
        chk_empty("drain1");

        // Push three with ID stalled: third is held until space opens.
        drive(1'b1, 32'h0, 1'b0); step();
        drive(1'b1, 32'h4, 1'b0); step();
        chk("full_rdy", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 32'h8, 1'b0); step();
        chk("held_rdy", {31'd0, in_ready}, 32'd0);
        chk_head("held_h0", 32'h0);
        drive(1'b1, 32'h8, 1'b1);
        chk_head("ord_0", 32'h0);
        step();
        chk("ord_rdy", {31'd0, in_ready}, 32'd1);
        chk_head("ord_4", 32'h4);
        step();                                  // pc 0x8 pushed while 0x4 pops
        drive(1'b0, 32'h0, 1'b1);
        chk_head("ord_8", 32'h8);
        step();
        chk_empty("drain2");

        // Continuous push+pop at count 1: pointers wrap several times.
        drive(1'b1, 32'h0, 1'b0); step();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(4 * (i + 1)), 1'b1);
            chk("stream_rdy", {31'd0, in_ready}, 32'd1);
            chk_head("stream", 32'(4 * i));
            step();
        end
        drive(1'b0, 32'h0, 1'b1);
        chk_head("stream_last", 32'h28);
        step();
        chk_empty("drain3");

        // Flush while full with a simultaneous push: the push is dropped.
        drive(1'b1, 32'h50, 1'b0); step();
        drive(1'b1, 32'h54, 1'b0); step();
        flush = 1'b1;
        drive(1'b1, 32'h40, 1'b0);
        chk("flush_rdy", {31'd0, in_ready}, 32'd1);
        step();
        flush = 1'b0;
        drive(1'b1, 32'h60, 1'b0);
        chk_empty("flushed");
        step();
        drive(1'b0, 32'h0, 1'b0);
        chk_head("postflush", 32'h60);

        // Reset mid-stream takes effect without waiting for a clock edge.
        rst = 1'b1;
        #1;
        chk_empty("midrst");
        chk("midrst_rdy", {31'd0, in_ready}, 32'd1);
        step();
        rst = 1'b0;
        #1;

        // ID ready while empty: no underflow, and bubbles are counted.
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) step();
        drive(1'b0, 32'h0, 1'b0);
        chk_empty("underflow");
`ifdef IFID_PERF_EN
        chk("bubble5", bubble_cnt, 32'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("bubble_flush", bubble_cnt, 32'd5);
`endif
        drive(1'b1, 32'h70, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0);
        chk_head("after_uf", 32'h70);
        chk("after_uf_rdy", {31'd0, in_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
